// File: rtl/icache_model_if.sv
// rtl/icache_model_if.sv - fetch request/response bundle for icache_model
//
// Purpose: groups the fetch request channel, the response channel, flush and
// the outstanding-request count into one bundle.
// Ports (signals):
//   flush_i       drop every outstanding request
//   addr_i        fetch address (XLEN)
//   addr_valid_i  request valid
//   addr_ready_o  request can be accepted
//   data_o        response line, word 0 in the LSBs (FETCH_WIDTH*ILEN)
//   err_o         response is for a misaligned address
//   data_valid_o  response valid
//   data_ready_i  consumer accepts response
//   outst_o       outstanding-request count
// Modports: master = requester/consumer side, slave = cache side.
interface icache_model_if #(
  parameter int XLEN        = 32,
  parameter int ILEN        = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int MAX_OUTST   = 4
);
  logic                         flush_i;
  logic [XLEN-1:0]              addr_i;
  logic                         addr_valid_i;
  logic                         addr_ready_o;
  logic [FETCH_WIDTH*ILEN-1:0]  data_o;
  logic                         err_o;
  logic                         data_valid_o;
  logic                         data_ready_i;
  logic [$clog2(MAX_OUTST):0]   outst_o;

  modport master (
    output flush_i, addr_i, addr_valid_i, data_ready_i,
    input  addr_ready_o, data_o, err_o, data_valid_o, outst_o
  );

  modport slave (
    input  flush_i, addr_i, addr_valid_i, data_ready_i,
    output addr_ready_o, data_o, err_o, data_valid_o, outst_o
  );
endinterface

// File: rtl/icache_model.sv
// rtl/icache_model.sv - fixed-latency in-order instruction fetch model
//
// Purpose: accepts fetch addresses, holds them in an in-order FIFO with a
// per-entry age counter and returns a line of FETCH_WIDTH words once the head
// entry has aged LATENCY cycles. Word k of a line is the aligned address plus
// 4*k; a misaligned address returns an all-zero line with err_o set.
// Ports:
//   clk_i  single clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    icache_model_if slave modport (request, response, flush, count)
module icache_model #(
  parameter int XLEN         = 32,
  parameter int ILEN         = 32,
  parameter int FETCH_WIDTH  = 2,
  parameter int LATENCY      = 2,
  parameter int MAX_OUTST    = 4,
  parameter int STALL_PERIOD = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  icache_model_if.slave bus
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int AW = $clog2(LATENCY + 1);

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t            PTR_LAST = ptr_t'(MAX_OUTST - 1);
  localparam logic [AW-1:0]   AGE_MAX  = AW'(LATENCY);
  localparam logic [OW-1:0]   OUTST_MAX = OW'(MAX_OUTST);

  logic [XLEN-1:0] fifo_addr [MAX_OUTST];
  logic [AW-1:0]   fifo_age  [MAX_OUTST];
  ptr_t            rd_ptr;
  ptr_t            wr_ptr;
  logic [OW-1:0]   outst;
  logic            stall;
  logic            head_ready;
  logic            accept;
  logic            consume;
  logic [XLEN-1:0] head_addr;
  logic [XLEN-1:0] head_base;

  // Pointers wrap at MAX_OUTST, which need not fill the pointer width.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  // Periodic back-pressure: the last count of each period is a stall cycle.
  if (STALL_PERIOD >= 1) begin : g_stall
    localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0] CNT_LAST = SW'(STALL_PERIOD - 1);
    logic [SW-1:0] stall_cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stall_cnt <= '0;
      end else if (stall_cnt == CNT_LAST) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end

    assign stall = (stall_cnt == CNT_LAST);
  end else begin : g_no_stall
    assign stall = 1'b0;
  end

  // Ready looks only at registered state plus flush, never at data_ready_i.
  assign bus.addr_ready_o = (outst < OUTST_MAX) && !bus.flush_i && !stall;
  assign accept           = bus.addr_valid_i && bus.addr_ready_o;

  assign head_ready       = (outst != '0) && (fifo_age[rd_ptr] == AGE_MAX);
  assign bus.data_valid_o = head_ready && !bus.flush_i;
  assign consume          = bus.data_valid_o && bus.data_ready_i;
  assign bus.outst_o      = outst;

  assign head_addr = fifo_addr[rd_ptr];
  assign head_base = {head_addr[XLEN-1:2], 2'b00};

  // The line is derived from the head entry, so it holds while the head waits.
  always_comb begin
    bus.data_o = '0;
    bus.err_o  = 1'b0;
    if (bus.data_valid_o) begin
      if (head_addr[1:0] != 2'b00) begin
        bus.err_o = 1'b1;
      end else begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
          bus.data_o[k*ILEN +: ILEN] = ILEN'(head_base + XLEN'(4 * k));
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      outst  <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        fifo_age[i]  <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      // Every entry ages independently so a stalled head does not hold back
      // the entries queued behind it.
      for (int i = 0; i < MAX_OUTST; i++) begin
        if (fifo_age[i] != AGE_MAX) begin
          fifo_age[i] <= fifo_age[i] + 1'b1;
        end
      end

      if (accept) begin
        fifo_addr[wr_ptr] <= bus.addr_i;
        fifo_age[wr_ptr]  <= AW'(1);
        wr_ptr            <= ptr_inc(wr_ptr);
      end

      // accept is already blocked by flush, so only the pointers need care.
      if (bus.flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        outst  <= '0;
      end else begin
        if (consume) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (accept && !consume) begin
          outst <= outst + 1'b1;
        end else if (!accept && consume) begin
          outst <= outst - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_model.sv
// tb/tb_icache_model.sv - scoreboard bench for icache_model
module tb_icache_model;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int FW   = 2;
  localparam int LAT  = 2;
  localparam int MO   = 4;

  typedef struct {
    logic [31:0] addr;
    int          acc;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  req_t q[$];
  bit   model_ready = 1'b0;
  bit   post_rst = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache_model_if #(.XLEN(XLEN), .ILEN(ILEN), .FETCH_WIDTH(FW), .MAX_OUTST(MO)) bus ();
  icache_model_if #(.XLEN(XLEN), .ILEN(ILEN), .FETCH_WIDTH(FW), .MAX_OUTST(MO)) sbus ();

  icache_model #(
    .XLEN(XLEN), .ILEN(ILEN), .FETCH_WIDTH(FW), .LATENCY(LAT),
    .MAX_OUTST(MO), .STALL_PERIOD(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  icache_model #(
    .XLEN(XLEN), .ILEN(ILEN), .FETCH_WIDTH(FW), .LATENCY(LAT),
    .MAX_OUTST(MO), .STALL_PERIOD(4)
  ) dut_s (
    .clk_i(clk), .rst_i(rst_s), .bus(sbus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference line: aligned base plus 4*k per word, 32-bit wraparound.
  function automatic logic [63:0] exp_line(input logic [31:0] a);
    logic [31:0] b;
    logic [63:0] l;
    l = '0;
    if (a[1:0] == 2'b00) begin
      b = a & 32'hFFFF_FFFC;
      for (int k = 0; k < FW; k++) l[k*32 +: 32] = b + 32'(4 * k);
    end
    return l;
  endfunction

  // Monitor: derives expected handshakes from the queue of accepted requests.
  always @(negedge clk) begin
    bit ev;
    bit er;
    if (rst) begin
      q.delete();
      model_ready = 1'b0;
      post_rst = 1'b1;
    end else begin
      er = (q.size() < MO) && !bus.flush_i;
      ev = !bus.flush_i && (q.size() > 0) && (cyc >= q[0].acc + LAT);
      model_ready = er;
      check("addr_ready", 64'(bus.addr_ready_o), 64'(er));
      check("data_valid", 64'(bus.data_valid_o), 64'(ev));
      check("outst", 64'(bus.outst_o), 64'(q.size()));
      if (post_rst) begin
        check("reset_data", bus.data_o, 64'd0);
        check("reset_err", 64'(bus.err_o), 64'd0);
        post_rst = 1'b0;
      end
      if (ev && bus.data_valid_o) begin
        check("data", bus.data_o, exp_line(q[0].addr));
        check("err", 64'(bus.err_o), 64'(q[0].addr[1:0] != 2'b00));
      end
      if (ev && bus.data_ready_i) void'(q.pop_front());
      if (bus.flush_i) q.delete();
    end
  end

  task automatic step(input bit v, input logic [31:0] a, input bit f, input bit r);
    bus.addr_valid_i = v;
    bus.addr_i       = a;
    bus.flush_i      = f;
    bus.data_ready_i = r;
    @(negedge clk);
    #1;
    if (!rst && v && model_ready) q.push_back('{addr: a, acc: cyc});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int          acc_cnt;
    logic [31:0] a;
    rst = 1'b1;
    rst_s = 1'b1;
    bus.addr_valid_i = 1'b0;  bus.addr_i = '0;  bus.flush_i = 1'b0;  bus.data_ready_i = 1'b1;
    sbus.addr_valid_i = 1'b0; sbus.addr_i = '0; sbus.flush_i = 1'b0; sbus.data_ready_i = 1'b1;

    // Periodic stall: ready low on cycles 3, 7, 11 after reset.
    repeat (2) @(posedge clk);
    #1;
    rst_s = 1'b0;
    sbus.addr_valid_i = 1'b1;
    sbus.addr_i = 32'h40;
    acc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("stall_ready", 64'(sbus.addr_ready_o), 64'((c % 4) != 3));
      if (sbus.addr_ready_o) acc_cnt++;
      @(posedge clk);
      #1;
      sbus.addr_i = $urandom & 32'hFFFF_FFFC;
    end
    check("stall_accepts", 64'(acc_cnt), 64'd9);
    sbus.addr_valid_i = 1'b0;

    rst = 1'b0;

    // Single request
    step(1, 32'h100, 0, 1);
    repeat (4) step(0, 0, 0, 1);

    // Fill with consumer blocked, then drain
    step(1, 32'h0, 0, 0);
    step(1, 32'h8, 0, 0);
    step(1, 32'h10, 0, 0);
    step(1, 32'h18, 0, 0);
    step(1, 32'h20, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);

    // Misaligned between aligned neighbours
    step(1, 32'h100, 0, 1);
    step(1, 32'h102, 0, 1);
    step(1, 32'h104, 0, 1);
    repeat (5) step(0, 0, 0, 1);

    // Flush with three outstanding while a request is offered
    step(1, 32'h200, 0, 0);
    step(1, 32'h204, 0, 0);
    step(1, 32'h208, 0, 0);
    step(0, 0, 0, 0);
    step(1, 32'h300, 1, 0);
    step(1, 32'h400, 0, 1);
    repeat (4) step(0, 0, 0, 1);

    // Address wraparound
    step(1, 32'hFFFF_FFFC, 0, 1);
    repeat (3) step(0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      step(1'($urandom_range(0, 1)), a, ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) != 0));
    end
    repeat (6) step(0, 0, 0, 1);

    // Reset with two outstanding
    step(1, 32'h500, 0, 0);
    step(1, 32'h504, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 1);
    rst = 1'b0;
    repeat (4) step(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
